// File: rtl/spi_port_if.sv
// spi_port_if -- CPU-side register bus of the SPI port.
//
// Signals:
//   cs    chip select from the CPU address decode (one 4 KB page)
//   we    write enable, meaningful only while cs=1
//   rs    register select (CPU_AB[1:0])
//   din   CPU write data
//   dout  registered read data
//   irq   level interrupt request, active-high
//
// Modports:
//   master  the CPU side: drives cs/we/rs/din, observes dout/irq
//   slave   the peripheral side: the reverse
interface spi_port_if;
  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output cs, output we, output rs, output din,
                  input  dout, input irq);
  modport slave  (input  cs, input  we, input  rs, input  din,
                  output dout, output irq);
endinterface

// File: rtl/spi_port.sv
// spi_port -- memory-mapped SPI master, mode 0 (SCLK idle low, MOSI
// launched on the falling edge, MISO sampled on the rising edge), MSB first.
//
// Register map (rs):
//   0 DATA    write: start an 8-bit transfer   read: last received byte
//   1 STATUS  read: {done, busy, wcol, 5'b0}   write: ignored
//   2 CTRL    {ien, 6'b0, ss}; ss drives spi_cs_n directly
//   3 DIV     SCLK half-period is DIV+1 clk cycles
//
// Ports:
//   clk       system clock, every state change on its rising edge
//   rst       synchronous reset, active-high
//   bus       CPU register bus (spi_port_if, slave side)
//   spi_sclk  SPI clock
//   spi_mosi  SPI data out
//   spi_miso  SPI data in
//   spi_cs_n  slave select, software controlled via CTRL.ss
module spi_port #(
  parameter logic [7:0] DIV_INIT = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  spi_port_if.slave  bus,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam logic [1:0] RS_DATA   = 2'd0;
  localparam logic [1:0] RS_STATUS = 2'd1;
  localparam logic [1:0] RS_CTRL   = 2'd2;
  localparam logic [1:0] RS_DIV    = 2'd3;

  state_e     state_q,    state_d;
  logic       done_q,     done_d;
  logic       wcol_q,     wcol_d;
  logic       ien_q,      ien_d;
  logic       ss_q,       ss_d;
  logic [7:0] div_q,      div_d;
  logic [7:0] div_snap_q, div_snap_d;  // DIV frozen for the running transfer
  logic [7:0] cnt_q,      cnt_d;       // clk cycles spent in current half-period
  logic [2:0] bit_cnt_q,  bit_cnt_d;   // falling edges completed so far
  logic [7:0] tx_q,       tx_d;
  logic [7:0] rx_q,       rx_d;
  logic [7:0] rx_data_q,  rx_data_d;   // byte visible to DATA reads
  logic [7:0] dout_q,     dout_d;
  logic       sclk_q,     sclk_d;
  logic       mosi_q,     mosi_d;

  logic       busy;
  logic       wr;
  logic       rd;
  logic       start;
  logic       half_done;
  logic [7:0] status;
  logic [7:0] rd_mux;

  assign busy      = (state_q != IDLE);
  assign wr        = bus.cs &  bus.we;
  assign rd        = bus.cs & ~bus.we;
  assign start     = wr && (bus.rs == RS_DATA) && !busy;
  assign half_done = (cnt_q == div_snap_q);
  assign status    = {done_q, busy, wcol_q, 5'b0};

  always_comb begin
    unique case (bus.rs)
      RS_DATA:   rd_mux = rx_data_q;
      RS_STATUS: rd_mux = status;
      RS_CTRL:   rd_mux = {ien_q, 6'b0, ss_q};
      default:   rd_mux = div_q;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the branches below leaves one unassigned and infers a latch.
    state_d    = state_q;
    done_d     = done_q;
    wcol_d     = wcol_q;
    ien_d      = ien_q;
    ss_d       = ss_q;
    div_d      = div_q;
    div_snap_d = div_snap_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    dout_d     = dout_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;

    // Register writes. A DATA write while busy only flags the collision.
    if (wr) begin
      unique case (bus.rs)
        RS_DATA: if (busy) wcol_d = 1'b1;
        RS_CTRL: begin
          ien_d = bus.din[7];
          ss_d  = bus.din[0];
        end
        RS_DIV:  div_d = bus.din;
        default: ;
      endcase
    end

    // Reads capture the current value first; the side-effect clears land
    // on the same edge and are visible from the next access on.
    if (rd) begin
      dout_d = rd_mux;
      if (bus.rs == RS_DATA)   done_d = 1'b0;
      if (bus.rs == RS_STATUS) wcol_d = 1'b0;
    end

    // Transfer engine. It runs after the read clears so that completion
    // on the same edge as a DATA read leaves done set.
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOW;
          done_d     = 1'b0;
          tx_d       = bus.din;
          mosi_d     = bus.din[7];
          sclk_d     = 1'b0;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          div_snap_d = div_q;
        end
      end
      LOW: begin
        if (half_done) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], spi_miso};
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (half_done) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            rx_data_d = rx_q;
            mosi_d    = 1'b0;
          end else begin
            state_d   = LOW;
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
            mosi_d    = tx_q[6];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      wcol_q     <= 1'b0;
      ien_q      <= 1'b0;
      ss_q       <= 1'b1;
      div_q      <= DIV_INIT;
      div_snap_q <= DIV_INIT;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      dout_q     <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wcol_q     <= wcol_d;
      ien_q      <= ien_d;
      ss_q       <= ss_d;
      div_q      <= div_d;
      div_snap_q <= div_snap_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      dout_q     <= dout_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.irq  = done_q & ien_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = ss_q;

endmodule

// File: tb/tb_spi_port.sv
// tb_spi_port -- self-checking bench for spi_port.
// Expected values come from the register-level rules: a transfer keeps busy
// for 16*(DIV+1) cycles, shifts the written byte out MSB first, and returns
// whatever the MISO source presented (loopback, all ones or all zeros).
module tb_spi_port;

  logic clk = 1'b0;
  logic rst;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_cs_n;

  int         checks = 0;
  int         errors = 0;
  int         miso_mode = 0;  // 0 loopback, 1 tied high, 2 tied low
  logic [7:0] last_rx;
  bit         mosi_bits[$];

  spi_port_if bus ();

  spi_port #(.DIV_INIT(8'd3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (miso_mode)
      0:       spi_miso = spi_mosi;
      1:       spi_miso = 1'b1;
      default: spi_miso = 1'b0;
    endcase
  end

  // Bit seen by the slave at each rising SCLK edge.
  always @(posedge spi_sclk) mosi_bits.push_back(spi_mosi);

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] rs, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.rs = rs; bus.din = d;
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] rs, output logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b0; bus.rs = rs;
    tick();
    d = bus.dout;
    bus.cs = 1'b0;
  endtask

  // One full transfer with STATUS polled every cycle. mid_div >= 0 writes DIV
  // on the cycle after the start, which must not affect this transfer.
  task automatic run_xfer(input logic [7:0] tx, input int div, input int mode,
                          input int mid_div, input bit ien, input string name);
    logic [7:0] exp_rx, d;
    int n_exp, k, k0, busy_cnt, hi_len, bad_runs, irq_bad;
    bit done_seen, bits_bad;
    exp_rx = (mode == 0) ? tx : ((mode == 1) ? 8'hFF : 8'h00);
    n_exp = 16 * (div + 1);
    miso_mode = mode;
    mosi_bits.delete();
    bus_write(2'd0, tx);
    k0 = 1;
    if (mid_div >= 0) begin
      bus_write(2'd3, mid_div[7:0]);
      k0 = 2;
    end
    bus.cs = 1'b1; bus.we = 1'b0; bus.rs = 2'd1;
    busy_cnt = 0; hi_len = 0; bad_runs = 0; irq_bad = 0; done_seen = 1'b0;
    k = k0;
    while (k < 5000) begin
      tick();
      if (spi_sclk) hi_len++;
      else if (hi_len != 0) begin
        if (hi_len != div + 1) bad_runs++;
        hi_len = 0;
      end
      if (bus.irq !== (ien && (k >= n_exp))) irq_bad++;
      if (bus.dout[6]) busy_cnt++;
      else begin
        done_seen = 1'b1;
        break;
      end
      k++;
    end
    bus.cs = 1'b0;

    checks++;
    if (!done_seen || busy_cnt != n_exp - (k0 - 1)) begin
      errors++;
      $display("FAIL %s busy_len got %0d want %0d (ended=%0b)", name, busy_cnt,
               n_exp - (k0 - 1), done_seen);
    end
    checks++;
    if (bus.dout !== 8'h80) begin
      errors++;
      $display("FAIL %s status_at_end got %h want 80", name, bus.dout);
    end
    checks++;
    if (bad_runs != 0) begin
      errors++;
      $display("FAIL %s sclk_high_width bad_runs %0d want 0 (width %0d)", name,
               bad_runs, div + 1);
    end
    bits_bad = (mosi_bits.size() != 8);
    if (!bits_bad)
      for (int i = 0; i < 8; i++) if (mosi_bits[i] !== tx[7-i]) bits_bad = 1'b1;
    checks++;
    if (bits_bad) begin
      errors++;
      $display("FAIL %s mosi_seq got %0d bits %p want %b", name, mosi_bits.size(),
               mosi_bits, tx);
    end
    checks++;
    if (irq_bad != 0) begin
      errors++;
      $display("FAIL %s irq_timing bad samples %0d want 0", name, irq_bad);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== exp_rx) begin
      errors++;
      $display("FAIL %s data_rx got %h want %h", name, d, exp_rx);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL %s irq_after_read got %b want 0", name, bus.irq);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL %s status_after_read got %h want 00", name, d);
    end
    last_rx = exp_rx;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] exp_r [4] = '{8'h00, 8'h00, 8'h01, 8'h03};
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.dout, spi_sclk, spi_mosi, spi_cs_n, bus.irq} !== {8'h00, 4'b0010}) begin
      errors++;
      $display("FAIL reset_pins got dout=%h sclk=%b mosi=%b cs_n=%b irq=%b want 00 0 0 1 0",
               bus.dout, spi_sclk, spi_mosi, spi_cs_n, bus.irq);
    end
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus_read(r[1:0], d);
      checks++;
      if (d !== exp_r[r]) begin
        errors++;
        $display("FAIL reset_reg%0d got %h want %h", r, d, exp_r[r]);
      end
    end
    bus_write(2'd1, 8'hFF);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL status_write_ignored got %h want 00", d);
    end
    last_rx = 8'h00;
  endtask

  task automatic test_loopback_div0();
    bus_write(2'd3, 8'd0);
    bus_write(2'd2, 8'h00);
    run_xfer(8'hA5, 0, 0, -1, 1'b0, "loop_div0");
  endtask

  task automatic test_miso_high_div3();
    bus_write(2'd3, 8'd3);
    run_xfer(8'h3C, 3, 1, -1, 1'b0, "ones_div3");
  endtask

  task automatic test_irq();
    bus_write(2'd2, 8'h80);
    bus_write(2'd3, 8'd1);
    run_xfer(8'($urandom), 1, 2, -1, 1'b1, "irq");
    bus_write(2'd2, 8'h00);
  endtask

  task automatic test_wcol();
    logic [7:0] d;
    int n;
    bus_write(2'd3, 8'd3);
    miso_mode = 1;
    mosi_bits.delete();
    bus_write(2'd0, 8'h96);
    repeat (3) tick();
    bus_write(2'd0, 8'h11);
    repeat (3) tick();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h60) begin
      errors++;
      $display("FAIL wcol_status got %h want 60", d);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h40) begin
      errors++;
      $display("FAIL wcol_cleared got %h want 40", d);
    end
    bus.cs = 1'b1; bus.we = 1'b0; bus.rs = 2'd1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.dout[6] && n < 200);
    bus.cs = 1'b0;
    checks++;
    if (bus.dout[6] || mosi_bits.size() != 8 ||
        {mosi_bits[0], mosi_bits[1], mosi_bits[2], mosi_bits[3],
         mosi_bits[4], mosi_bits[5], mosi_bits[6], mosi_bits[7]} !== 8'h96) begin
      errors++;
      $display("FAIL wcol_mosi got %0d bits %p busy=%b want 96", mosi_bits.size(),
               mosi_bits, bus.dout[6]);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL wcol_data got %h want ff", d);
    end
    last_rx = 8'hFF;
  endtask

  task automatic test_div_midway();
    bus_write(2'd3, 8'd1);
    run_xfer(8'($urandom), 1, 0, 4, 1'b0, "div_mid_old");
    run_xfer(8'($urandom), 4, 0, -1, 1'b0, "div_mid_new");
  endtask

  task automatic test_random();
    int div, mode;
    bit ien;
    logic [7:0] tx;
    for (int i = 0; i < 6; i++) begin
      div  = $urandom_range(0, 4);
      mode = $urandom_range(0, 2);
      ien  = 1'($urandom);
      tx   = 8'($urandom);
      bus_write(2'd3, div[7:0]);
      bus_write(2'd2, {ien, 7'b0});
      run_xfer(tx, div, mode, -1, ien, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] d;
    bus_write(2'd3, 8'd0);
    bus_write(2'd2, 8'h80);
    miso_mode = 1;
    bus_write(2'd0, 8'hFF);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({spi_sclk, spi_mosi, spi_cs_n, bus.irq} !== 4'b0010) begin
      errors++;
      $display("FAIL rst_mid_pins got sclk=%b mosi=%b cs_n=%b irq=%b want 0 0 1 0",
               spi_sclk, spi_mosi, spi_cs_n, bus.irq);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 8'h03) begin
      errors++;
      $display("FAIL rst_mid_div got %h want 03", d);
    end
    repeat (40) tick();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00 || bus.irq !== 1'b0 || spi_sclk !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_aborted got status=%h irq=%b sclk=%b want 00 0 0", d,
               bus.irq, spi_sclk);
    end
    last_rx = 8'h00;
  endtask

  task automatic test_done_race();
    logic [7:0] d, tx;
    tx = 8'($urandom);
    bus_write(2'd3, 8'd0);
    bus_write(2'd2, 8'h80);
    miso_mode = 0;
    bus_write(2'd0, tx);
    repeat (15) tick();
    bus_read(2'd0, d);  // lands on the 16th edge after the start
    checks++;
    if (d !== last_rx) begin
      errors++;
      $display("FAIL race_old_data got %h want %h", d, last_rx);
    end
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL race_irq got %b want 1", bus.irq);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h80) begin
      errors++;
      $display("FAIL race_status got %h want 80", d);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== tx || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL race_new_data got %h irq=%b want %h irq=0", d, bus.irq, tx);
    end
    last_rx = tx;
  endtask

  initial begin
    rst = 1'b1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.rs = 2'd0; bus.din = 8'h00;
    test_reset();
    test_loopback_div0();
    test_miso_high_div3();
    test_irq();
    test_wcol();
    test_div_midway();
    test_random();
    test_rst_mid();
    test_done_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_port.md
SPI_PORT -- requirements
Module: spi_port

Interface
REQ-001 Parameter: DIV_INIT, default 8'd3, reset value of the DIV register.
REQ-002 clk  input  1  system/CPU clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 cs  input  1  chip select from the CPU address decode, one full 4 KB page.
REQ-005 we  input  1  CPU write enable, valid when cs=1.
REQ-006 rs  input  2  register select, CPU_AB[1:0].
REQ-007 din  input  8  CPU write data.
REQ-008 dout  output  8  registered read data.
REQ-009 irq  output  1  level interrupt request, active-high.
REQ-010 spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-011 spi_mosi  output  1  SPI data out, MSB first.
REQ-012 spi_miso  input  1  SPI data in, sampled on rising spi_sclk.
REQ-013 spi_cs_n  output  1  slave select, software controlled.

Function
REQ-014 Register map: rs=0 DATA, rs=1 STATUS (read) / none (write), rs=2 CTRL, rs=3 DIV.
REQ-015 A bus access is an edge where cs=1; write if we=1, read if we=0.
REQ-016 Read: dout SHALL load the selected register on the access edge and hold otherwise, giving 1-cycle read latency.
REQ-017 STATUS = {done, busy, wcol, 5'b0}.
REQ-018 CTRL = {ien, 6'b0, ss}; spi_cs_n SHALL equal ss.
REQ-019 DIV SHALL be an 8-bit half-period; one SCLK half-period = DIV+1 clk cycles.
REQ-020 Write DATA with busy=0: on that edge busy<=1, done<=0, tx shift<=din, spi_mosi<=din[7], spi_sclk=0, phase counter cleared, DIV snapshot latched.
REQ-021 Write DATA with busy=1: data ignored, transfer unaffected, wcol<=1.
REQ-022 FSM states IDLE, LOW, HIGH: IDLE->LOW on start; LOW->HIGH after DIV+1 cycles (sclk rises, spi_miso sampled into rx shift LSB); HIGH->LOW after DIV+1 cycles (sclk falls, next bit on spi_mosi); HIGH->IDLE on the 8th falling edge.
REQ-023 Transfer length: busy SHALL stay high exactly 16*(DIV+1) cycles after the start edge.
REQ-024 On entry to IDLE: busy<=0, done<=1, DATA read register<=received byte, spi_mosi<=0.
REQ-025 Writes to DIV during a transfer SHALL apply only to the next transfer.
REQ-026 Read DATA clears done; read STATUS clears wcol; both after the current value is captured in dout.
REQ-027 Completion on the same edge as a DATA read: done SHALL end set.
REQ-028 irq = done & ien, combinational from registered state.
REQ-029 Writes to rs=1 SHALL have no effect.

Reset
REQ-030 On rst: FSM IDLE, busy=0, done=0, wcol=0, ien=0, ss=1 (spi_cs_n=1), DIV=DIV_INIT, rx/tx=0, dout=0, spi_sclk=0, spi_mosi=0, irq=0.
REQ-031 rst mid-transfer SHALL abort at once with no done and no irq.

Verification
REQ-032 DIV=0, write CTRL=0x00, write DATA=0xA5, miso loopback -> 8 SCLK pulses each 2 cycles; busy for 16 cycles; DATA reads 0xA5; done cleared.
REQ-033 DIV=3, write DATA=0x3C, miso tied 1 -> busy exactly 64 cycles; mosi sequence 0,0,1,1,1,1,0,0; DATA reads 0xFF.
REQ-034 CTRL=0x80, transfer completes -> irq rises with done; DATA read -> irq low next cycle.
REQ-035 Write DATA=0x11 mid-transfer of 0x96 -> wcol=1, mosi carries 0x96 only; STATUS read returns 0x60, then wcol=0.
REQ-036 rst at cycle 5 of a transfer -> sclk=0, busy=0, done=0, spi_cs_n=1, DIV=DIV_INIT next cycle.
REQ-037 DATA read on the completion edge of a transfer -> done=1 afterward and irq asserted if ien=1.
